// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared definitions for the two-requester round-robin mux arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT_A, GRANT_B)
//   SEL_A/SEL_B : mux select encodings (0 = requester A, 1 = requester B)
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : mux_arb_pkg

// File: rtl/mux_out_reg.sv
// mux_out_reg: single-entry valid/ready output register.
//   Holds one beat (data + last). A load always wins over a drain, so a
//   drain and a load in the same cycle keep the slot full with the new beat.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_load         : a beat is accepted this cycle (caller guarantees slot free or draining)
//   i_data, i_last : beat contents to load
//   i_ready        : downstream ready
//   o_valid, o_data, o_last : registered output beat
module mux_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  // Output slot: loaded by an accepted beat, emptied when drained without a reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule : mux_out_reg

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin packet arbiter sequencing a shared 2:1 data mux.
//   A grant is held for a whole packet (until the accepted beat carrying last);
//   when both sides contend in IDLE the side that did not win last time wins.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   a_valid/a_data/a_last      : requester A beat;  a_ready: A beat accepted
//   b_valid/b_data/b_last      : requester B beat;  b_ready: B beat accepted
//   out_valid/out_data/out_last: registered output beat; out_ready from downstream
//   sel                        : mux select (0 = A, 1 = B), stable for a packet
//   busy                       : a packet grant is held
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
);

  arb_state_t r_state;
  logic       r_prio_last;
  logic       r_sel;
  logic       r_busy;

  logic              w_slot_free;
  logic              w_acc_a;
  logic              w_acc_b;
  logic              w_load;
  logic [DATA_W-1:0] w_mux_data;
  logic              w_mux_last;

  // Output slot can take a beat if empty or being drained this cycle
  assign w_slot_free = !out_valid || out_ready;

  assign a_ready = (r_state == GRANT_A) && w_slot_free;
  assign b_ready = (r_state == GRANT_B) && w_slot_free;

  assign w_acc_a = a_valid && a_ready;
  assign w_acc_b = b_valid && b_ready;
  assign w_load  = w_acc_a || w_acc_b;

  // The shared 2:1 mux; r_sel always matches the granted side
  assign w_mux_data = (r_sel == SEL_B) ? b_data : a_data;
  assign w_mux_last = (r_sel == SEL_B) ? b_last : a_last;

  // Arbitration FSM: select, priority and busy all change only with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_prio_last <= SEL_B;
      r_sel       <= SEL_A;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // A wins if alone, or on contention when B won last time
          if (a_valid && (!b_valid || r_prio_last == SEL_B)) begin
            r_state     <= GRANT_A;
            r_sel       <= SEL_A;
            r_prio_last <= SEL_A;
            r_busy      <= 1'b1;
          end else if (b_valid) begin
            r_state     <= GRANT_B;
            r_sel       <= SEL_B;
            r_prio_last <= SEL_B;
            r_busy      <= 1'b1;
          end
        end
        GRANT_A: begin
          if (w_acc_a && a_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        GRANT_B: begin
          if (w_acc_b && b_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sel  = r_sel;
  assign busy = r_busy;

  mux_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_data  (w_mux_data),
    .i_last  (w_mux_last),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_last  (out_last)
  );

endmodule : mux2_rr_arbiter

// File: tb/tb_mux2_rr_arbiter.sv
// Testbench for mux2_rr_arbiter: directed vector tables plus hand-written
// sequences for arbitration alternation and asynchronous reset mid-packet.
// Inputs change just after the falling edge; outputs are sampled 2 time
// units later, i.e. well before the next rising edge.
module tb_mux2_rr_arbiter;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              a_valid, a_last, a_ready;
  logic [DATA_W-1:0] a_data;
  logic              b_valid, b_last, b_ready;
  logic [DATA_W-1:0] b_data;
  logic              out_valid, out_last, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              sel, busy;

  int checks;
  int failures;

  mux2_rr_arbiter #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_last    (a_last),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_last    (b_last),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       av;
    logic [7:0] ad;
    logic       al;
    logic       bv;
    logic [7:0] bd;
    logic       bl;
    logic       ordy;
    logic       ear;
    logic       ebr;
    logic       eov;
    logic [7:0] eod;
    logic       eol;
    logic       esel;
    logic       ebusy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int av, int ad, int al, int bv, int bd, int bl, int ordy,
                              int ar, int br, int ov, int od, int ol, int sl, int bz);
    vec_t v;
    v.av = 1'(av);   v.ad = 8'(ad);   v.al = 1'(al);
    v.bv = 1'(bv);   v.bd = 8'(bd);   v.bl = 1'(bl);
    v.ordy = 1'(ordy);
    v.ear = 1'(ar);  v.ebr = 1'(br);  v.eov = 1'(ov);
    v.eod = 8'(od);  v.eol = 1'(ol);  v.esel = 1'(sl); v.ebusy = 1'(bz);
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic av, logic [7:0] ad, logic al,
                       logic bv, logic [7:0] bd, logic bl, logic ordy);
    a_valid = av; a_data = ad; a_last = al;
    b_valid = bv; b_data = bd; b_last = bl;
    out_ready = ordy;
  endtask

  task automatic run_vecs(string tag);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].av, vq[i].ad, vq[i].al, vq[i].bv, vq[i].bd, vq[i].bl, vq[i].ordy);
      #2;
      chk($sformatf("%s[%0d].a_ready", tag, i),   32'(a_ready),   32'(vq[i].ear));
      chk($sformatf("%s[%0d].b_ready", tag, i),   32'(b_ready),   32'(vq[i].ebr));
      chk($sformatf("%s[%0d].out_valid", tag, i), 32'(out_valid), 32'(vq[i].eov));
      chk($sformatf("%s[%0d].out_data", tag, i),  32'(out_data),  32'(vq[i].eod));
      chk($sformatf("%s[%0d].out_last", tag, i),  32'(out_last),  32'(vq[i].eol));
      chk($sformatf("%s[%0d].sel", tag, i),       32'(sel),       32'(vq[i].esel));
      chk($sformatf("%s[%0d].busy", tag, i),      32'(busy),      32'(vq[i].ebusy));
    end
    vq.delete();
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, ".a_ready"},   32'(a_ready),   32'd0);
    chk({tag, ".b_ready"},   32'(b_ready),   32'd0);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_data"},  32'(out_data),  32'd0);
    chk({tag, ".out_last"},  32'(out_last),  32'd0);
    chk({tag, ".sel"},       32'(sel),       32'd0);
    chk({tag, ".busy"},      32'(busy),      32'd0);
  endtask

  logic       exp_sel;
  logic [7:0] prev_d;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no requests for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      chk_all_zero($sformatf("idle[%0d]", i));
    end

    // Simultaneous first requests: A (3 beats) wins, then B (2 beats),
    // followed by a single-beat A packet.
    //               av ad   al bv bd   bl rdy  ar br ov od   ol sel busy
    vq.push_back(mk(1, 'h11, 0, 1, 'h21, 0, 1,  0, 0, 0, 'h00, 0, 0, 0));
    vq.push_back(mk(1, 'h11, 0, 1, 'h21, 0, 1,  1, 0, 0, 'h00, 0, 0, 1));
    vq.push_back(mk(1, 'h12, 0, 1, 'h21, 0, 1,  1, 0, 1, 'h11, 0, 0, 1));
    vq.push_back(mk(1, 'h13, 1, 1, 'h21, 0, 1,  1, 0, 1, 'h12, 0, 0, 1));
    vq.push_back(mk(0, 'h00, 0, 1, 'h21, 0, 1,  0, 0, 1, 'h13, 1, 0, 0));
    vq.push_back(mk(0, 'h00, 0, 1, 'h21, 0, 1,  0, 1, 0, 'h13, 1, 1, 1));
    vq.push_back(mk(0, 'h00, 0, 1, 'h22, 1, 1,  0, 1, 1, 'h21, 0, 1, 1));
    vq.push_back(mk(0, 'h00, 0, 0, 'h00, 0, 1,  0, 0, 1, 'h22, 1, 1, 0));
    vq.push_back(mk(0, 'h00, 0, 0, 'h00, 0, 1,  0, 0, 0, 'h22, 1, 1, 0));
    vq.push_back(mk(1, 'h5A, 1, 0, 'h00, 0, 1,  0, 0, 0, 'h22, 1, 1, 0));
    vq.push_back(mk(1, 'h5A, 1, 0, 'h00, 0, 1,  1, 0, 0, 'h22, 1, 0, 1));
    vq.push_back(mk(0, 'h00, 0, 0, 'h00, 0, 1,  0, 0, 1, 'h5A, 1, 0, 0));
    vq.push_back(mk(0, 'h00, 0, 0, 'h00, 0, 1,  0, 0, 0, 'h5A, 1, 0, 0));
    run_vecs("pkt");

    // Both sides sending single-beat packets back to back: the last winner
    // was A, so B wins first and the grant alternates from there.
    exp_sel = 1'b1;
    prev_d  = 8'h00;
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      drive(1, 8'(8'hA0 + p), 1, 1, 8'(8'hB0 + p), 1, 1);
      #2;
      chk($sformatf("alt[%0d].idle_busy", p), 32'(busy), 32'd0);
      if (p > 0) begin
        chk($sformatf("alt[%0d].out_valid", p), 32'(out_valid), 32'd1);
        chk($sformatf("alt[%0d].out_data", p),  32'(out_data),  32'(prev_d));
      end
      @(negedge clk);
      #2;
      chk($sformatf("alt[%0d].sel", p),     32'(sel),     32'(exp_sel));
      chk($sformatf("alt[%0d].a_ready", p), 32'(a_ready), 32'(!exp_sel));
      chk($sformatf("alt[%0d].b_ready", p), 32'(b_ready), 32'(exp_sel));
      prev_d  = exp_sel ? 8'(8'hB0 + p) : 8'(8'hA0 + p);
      exp_sel = !exp_sel;
    end
    @(negedge clk);
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    #2;
    chk("alt_end.out_valid", 32'(out_valid), 32'd1);
    chk("alt_end.out_data",  32'(out_data),  32'(prev_d));
    chk("alt_end.busy",      32'(busy),      32'd0);

    // Backpressure: out_ready low for 4 cycles mid-packet
    //               av ad   al bv bd   bl rdy  ar br ov od   ol sel busy
    vq.push_back(mk(1, 'h31, 0, 0, 'h00, 0, 1,  0, 0, 0, 'hA5, 1, 0, 0));
    vq.push_back(mk(1, 'h31, 0, 0, 'h00, 0, 1,  1, 0, 0, 'hA5, 1, 0, 1));
    vq.push_back(mk(1, 'h32, 0, 0, 'h00, 0, 1,  1, 0, 1, 'h31, 0, 0, 1));
    vq.push_back(mk(1, 'h33, 0, 0, 'h00, 0, 0,  0, 0, 1, 'h32, 0, 0, 1));
    vq.push_back(mk(1, 'h33, 0, 0, 'h00, 0, 0,  0, 0, 1, 'h32, 0, 0, 1));
    vq.push_back(mk(1, 'h33, 0, 0, 'h00, 0, 0,  0, 0, 1, 'h32, 0, 0, 1));
    vq.push_back(mk(1, 'h33, 0, 0, 'h00, 0, 0,  0, 0, 1, 'h32, 0, 0, 1));
    vq.push_back(mk(1, 'h33, 0, 0, 'h00, 0, 1,  1, 0, 1, 'h32, 0, 0, 1));
    vq.push_back(mk(1, 'h34, 0, 0, 'h00, 0, 1,  1, 0, 1, 'h33, 0, 0, 1));
    vq.push_back(mk(1, 'h35, 0, 0, 'h00, 0, 1,  1, 0, 1, 'h34, 0, 0, 1));
    vq.push_back(mk(1, 'h36, 1, 0, 'h00, 0, 1,  1, 0, 1, 'h35, 0, 0, 1));
    vq.push_back(mk(0, 'h00, 0, 0, 'h00, 0, 1,  0, 0, 1, 'h36, 1, 0, 0));
    run_vecs("bp");

    // B waits while A's packet has valid gaps; grant never leaves A early
    //               av ad   al bv bd   bl rdy  ar br ov od   ol sel busy
    vq.push_back(mk(1, 'h41, 0, 0, 'h00, 0, 1,  0, 0, 0, 'h36, 1, 0, 0));
    vq.push_back(mk(1, 'h41, 0, 1, 'h51, 1, 1,  1, 0, 0, 'h36, 1, 0, 1));
    vq.push_back(mk(0, 'h00, 0, 1, 'h51, 1, 1,  1, 0, 1, 'h41, 0, 0, 1));
    vq.push_back(mk(0, 'h00, 0, 1, 'h51, 1, 1,  1, 0, 0, 'h41, 0, 0, 1));
    vq.push_back(mk(1, 'h42, 0, 1, 'h51, 1, 1,  1, 0, 0, 'h41, 0, 0, 1));
    vq.push_back(mk(0, 'h00, 0, 1, 'h51, 1, 1,  1, 0, 1, 'h42, 0, 0, 1));
    vq.push_back(mk(1, 'h43, 1, 1, 'h51, 1, 1,  1, 0, 0, 'h42, 0, 0, 1));
    vq.push_back(mk(0, 'h00, 0, 1, 'h51, 1, 1,  0, 0, 1, 'h43, 1, 0, 0));
    vq.push_back(mk(0, 'h00, 0, 1, 'h51, 1, 1,  0, 1, 0, 'h43, 1, 1, 1));
    vq.push_back(mk(0, 'h00, 0, 0, 'h00, 0, 1,  0, 0, 1, 'h51, 1, 1, 0));
    run_vecs("gap");

    // Reset asserted during B's second beat
    @(negedge clk);
    drive(0, 8'h00, 0, 1, 8'h61, 0, 1);
    #2;
    chk("rst_seq.idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2;
    chk("rst_seq.b_ready", 32'(b_ready), 32'd1);
    chk("rst_seq.sel",     32'(sel),     32'd1);
    @(negedge clk);
    drive(0, 8'h00, 0, 1, 8'h62, 0, 1);
    #2;
    chk("rst_seq.pre_out_data", 32'(out_data), 32'h61);
    chk("rst_seq.pre_b_ready",  32'(b_ready),  32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    @(negedge clk);
    chk_all_zero("rst_held");
    rst_n = 1'b1;
    drive(1, 8'h71, 1, 1, 8'h81, 1, 1);
    #2;
    chk("post_rst.idle_busy", 32'(busy),    32'd0);
    chk("post_rst.a_ready0",  32'(a_ready), 32'd0);
    @(negedge clk);
    #2;
    chk("post_rst.sel",     32'(sel),     32'd0);
    chk("post_rst.a_ready", 32'(a_ready), 32'd1);
    chk("post_rst.b_ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    drive(0, 8'h00, 0, 1, 8'h81, 1, 1);
    #2;
    chk("post_rst.out_data_a", 32'(out_data),  32'h71);
    chk("post_rst.out_last_a", 32'(out_last),  32'd1);
    chk("post_rst.out_valid",  32'(out_valid), 32'd1);
    chk("post_rst.busy_gap",   32'(busy),      32'd0);
    @(negedge clk);
    #2;
    chk("post_rst.sel_b",   32'(sel),     32'd1);
    chk("post_rst.b_ready", 32'(b_ready), 32'd1);
    @(negedge clk);
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    #2;
    chk("post_rst.out_data_b", 32'(out_data), 32'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux2_rr_arbiter
